// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage add/subtract pipeline with valid/ready handshake,
// NZCV flags on the delivered result and a sticky signed-overflow indicator.
// Optional feature: define ADDSUB_SAT_EN to clamp signed-overflowing results
// to the signed extreme (V and C keep their raw values; N and Z follow the
// clamped sum). Without the macro the result wraps modulo 2^WIDTH.
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    // Stage 1: adder operands (b already conditioned for subtract) and carry-in
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;

    // Stage 2: delivered result and flags
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_sticky;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_xfer;
    logic             w_s2_load;
    logic             w_out_xfer;
    logic [WIDTH:0]   w_raw;
    logic             w_v;
    logic             w_c;
    logic [WIDTH-1:0] w_res;
    logic             w_n;
    logic             w_z;

`ifdef ADDSUB_SAT_EN
    // On overflow the true result has the sign of a, so clamp toward that side.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf,
                                                  input logic             a_msb);
        if (!ovf)
            return raw;
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // A stage may move forward when the stage after it is empty or draining now.
    assign w_s2_adv   = !r_s2_vld || out_ready;
    assign w_s1_adv   = !r_s1_vld || w_s2_adv;
    assign w_in_xfer  = in_valid && w_s1_adv;
    assign w_s2_load  = r_s1_vld && w_s2_adv;
    assign w_out_xfer = r_s2_vld && out_ready;

    // Single (WIDTH+1)-bit adder; subtract is a + ~b + 1.
    assign w_raw = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, r_s1_cin};
    assign w_c   = w_raw[WIDTH];
    assign w_v   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                   (w_raw[WIDTH-1] != r_s1_a[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    assign w_res = saturate(w_raw[WIDTH-1:0], w_v, r_s1_a[WIDTH-1]);
`else
    assign w_res = w_raw[WIDTH-1:0];
`endif

    assign w_n = w_res[WIDTH-1];
    assign w_z = (w_res == '0);

    // Pipeline occupancy and the sticky overflow flag; a set on delivery beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            if (w_s1_adv)
                r_s1_vld <= in_valid;
            if (w_s2_adv)
                r_s2_vld <= r_s1_vld;
            if (w_out_xfer && r_v)
                r_sticky <= 1'b1;
            else if (clr_sticky)
                r_sticky <= 1'b0;
        end
    end

    // Stage 1 data: capture operands on an input transfer; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_a   <= a;
            r_s1_b   <= b ^ {WIDTH{sub}};
            r_s1_cin <= sub;
        end
    end

    // Stage 2 data: load only with a real operation so the outputs hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
            r_n   <= 1'b0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
        end else if (w_s2_load) begin
            r_sum <= w_res;
            r_n   <= w_n;
            r_z   <= w_z;
            r_c   <= w_c;
            r_v   <= w_v;
        end
    end

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_vld;
    assign sum        = r_sum;
    assign N          = r_n;
    assign Z          = r_z;
    assign C          = r_c;
    assign V          = r_v;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: an 8-bit instance for directed vectors and a 16-bit
// instance for directed plus random traffic. A transaction-level model (queues
// of expected results computed with signed/unsigned integer arithmetic) is
// compared against both instances on every falling edge.
module tb_addsub_pipe;

    typedef struct packed {
        logic [63:0] sum;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
        int          age;
    } exp_t;

    logic        clk;
    logic        rstn;

    logic        iv8, ir8, sub8, ov8, ordy8, n8, z8, c8, v8, stk8, clr8;
    logic [7:0]  a8, b8, sum8;
    logic        iv16, ir16, sub16, ov16, ordy16, n16, z16, c16, v16, stk16, clr16;
    logic [15:0] a16, b16, sum16;

    int n_pass;
    int n_total;

    exp_t q8[$];
    exp_t q16[$];
    exp_t held8, held16;
    logic m_stk8, m_stk16;

    addsub_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(sum8),
        .N(n8), .Z(z8), .C(c8), .V(v8), .ovf_sticky(stk8), .clr_sticky(clr8)
    );

    addsub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rstn(rstn), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .sum(sum16),
        .N(n16), .Z(z16), .C(c16), .V(v16), .ovf_sticky(stk16), .clr_sticky(clr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t ref_op(int w, logic [63:0] a, logic [63:0] b, logic sub);
        exp_t   e;
        longint mask, half, ua, ub, sa, sb, sres, full;
        mask = (longint'(1) <<< w) - 1;
        half = longint'(1) <<< (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        if (sub) begin
            sres = sa - sb;
            full = ua - ub;
            e.c  = (ua >= ub);
        end else begin
            sres = sa + sb;
            full = ua + ub;
            e.c  = (full > mask);
        end
        e.v   = (sres > half - 1) || (sres < -half);
        e.sum = 64'(full & mask);
`ifdef ADDSUB_SAT_EN
        if (e.v)
            e.sum = (sres > 0) ? 64'(half - 1) : 64'(half);
`endif
        e.n   = (e.sum >= 64'(half));
        e.z   = (e.sum == 64'd0);
        e.age = 0;
        return e;
    endfunction

    // Model update for the 8-bit instance.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q8.delete();
            held8  = '0;
            m_stk8 = 1'b0;
        end else begin
            logic rdy, dlv;
            rdy = (q8.size() < 2) || ordy8;
            dlv = (q8.size() > 0) && (q8[0].age >= 1) && ordy8;
            if (dlv && q8[0].v)
                m_stk8 = 1'b1;
            else if (clr8)
                m_stk8 = 1'b0;
            if (dlv)
                held8 = q8.pop_front();
            foreach (q8[i]) q8[i].age = q8[i].age + 1;
            if (iv8 && rdy)
                q8.push_back(ref_op(8, 64'(a8), 64'(b8), sub8));
        end
    end

    // Model update for the 16-bit instance.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q16.delete();
            held16  = '0;
            m_stk16 = 1'b0;
        end else begin
            logic rdy, dlv;
            rdy = (q16.size() < 2) || ordy16;
            dlv = (q16.size() > 0) && (q16[0].age >= 1) && ordy16;
            if (dlv && q16[0].v)
                m_stk16 = 1'b1;
            else if (clr16)
                m_stk16 = 1'b0;
            if (dlv)
                held16 = q16.pop_front();
            foreach (q16[i]) q16[i].age = q16[i].age + 1;
            if (iv16 && rdy)
                q16.push_back(ref_op(16, 64'(a16), 64'(b16), sub16));
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic vis;
        vis = (q8.size() > 0) && (q8[0].age >= 1);
        e   = vis ? q8[0] : held8;
        chk("out_valid8", 64'(ov8), 64'(vis));
        chk("in_ready8", 64'(ir8), 64'((q8.size() < 2) || ordy8));
        chk("sum8", 64'(sum8), e.sum);
        chk("nzcv8", 64'({n8, z8, c8, v8}), 64'({e.n, e.z, e.c, e.v}));
        chk("sticky8", 64'(stk8), 64'(m_stk8));
        vis = (q16.size() > 0) && (q16[0].age >= 1);
        e   = vis ? q16[0] : held16;
        chk("out_valid16", 64'(ov16), 64'(vis));
        chk("in_ready16", 64'(ir16), 64'((q16.size() < 2) || ordy16));
        chk("sum16", 64'(sum16), e.sum);
        chk("nzcv16", 64'({n16, z16, c16, v16}), 64'({e.n, e.z, e.c, e.v}));
        chk("sticky16", 64'(stk16), 64'(m_stk16));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        n_pass = 0; n_total = 0;
        rstn = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; sub8 = 0; ordy8 = 1; clr8 = 0;
        iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; ordy16 = 1; clr16 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_sum", 64'(sum8), 64'd0);
        chk("rst_in_ready", 64'(ir8), 64'd1);

        // 0x55 + 0x44 offered on release; taken on the first edge with rstn=1
        #1 rstn = 1'b1; iv8 = 1; a8 = 8'h55; b8 = 8'h44; sub8 = 0;
        @(posedge clk); #1 iv8 = 0;
        @(posedge clk); @(negedge clk);
        chk("add_valid", 64'(ov8), 64'd1);
`ifdef ADDSUB_SAT_EN
        chk("add_sum", 64'(sum8), 64'h7F);
        chk("add_nzcv", 64'({n8, z8, c8, v8}), 64'b0001);
`else
        chk("add_sum", 64'(sum8), 64'h99);
        chk("add_nzcv", 64'({n8, z8, c8, v8}), 64'b1001);
`endif
        @(posedge clk); @(negedge clk);
        chk("add_sticky", 64'(stk8), 64'd1);

        // Back-to-back subtracts, results on consecutive cycles
        @(posedge clk); #1 iv8 = 1; a8 = 8'hFF; b8 = 8'h80; sub8 = 1;
        @(posedge clk); #1 a8 = 8'h01; b8 = 8'h10;
        @(posedge clk); #1 a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        chk("sub0_sum", 64'(sum8), 64'h7F);
        chk("sub0_nzcv", 64'({n8, z8, c8, v8}), 64'b0010);
        @(posedge clk); #1 iv8 = 0;
        @(negedge clk);
        chk("sub1_valid", 64'(ov8), 64'd1);
        chk("sub1_sum", 64'(sum8), 64'hF1);
        chk("sub1_nzcv", 64'({n8, z8, c8, v8}), 64'b1000);
        @(posedge clk); @(negedge clk);
        chk("sub2_sum", 64'(sum8), 64'h00);
        chk("sub2_nzcv", 64'({n8, z8, c8, v8}), 64'b0110);

        // Backpressure: three offered, two held, third waits
        @(posedge clk); #1 ordy8 = 0; iv8 = 1; a8 = 8'h10; b8 = 8'h20; sub8 = 0;
        @(posedge clk); #1 a8 = 8'h03; b8 = 8'h04;
        @(posedge clk); #1 a8 = 8'h40; b8 = 8'h01; sub8 = 1;
        @(negedge clk);
        chk("bp_in_ready", 64'(ir8), 64'd0);
        chk("bp_sum_a", 64'(sum8), 64'h30);
        @(posedge clk); @(negedge clk);
        chk("bp_frozen_sum", 64'(sum8), 64'h30);
        chk("bp_frozen_valid", 64'(ov8), 64'd1);
        #1 ordy8 = 1;
        @(posedge clk); #1 iv8 = 0;
        @(negedge clk);
        chk("bp_sum_b", 64'(sum8), 64'h07);
        @(posedge clk); @(negedge clk);
        chk("bp_sum_c", 64'(sum8), 64'h3F);
        chk("bp_nzcv_c", 64'({n8, z8, c8, v8}), 64'b0010);

        // Reset while both stages are full
        @(posedge clk); #1 ordy8 = 0; iv8 = 1; a8 = 8'h11; b8 = 8'h22; sub8 = 0;
        @(posedge clk); #1 a8 = 8'h33; b8 = 8'h01;
        @(posedge clk); #1 iv8 = 0;
        @(negedge clk);
        chk("full_in_ready", 64'(ir8), 64'd0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(ov8), 64'd0);
        chk("arst_sum", 64'(sum8), 64'd0);
        chk("arst_nzcv", 64'({n8, z8, c8, v8}), 64'd0);
        chk("arst_sticky", 64'(stk8), 64'd0);
        ordy8 = 1;
        @(posedge clk); @(negedge clk); #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_valid", 64'(ov8), 64'd0);

        // Sticky: clear coincident with a V=1 delivery, then clear alone
        #1 iv8 = 1; a8 = 8'h55; b8 = 8'h44; sub8 = 0;
        @(posedge clk); #1 iv8 = 0;
        @(posedge clk); #1 clr8 = 1;
        @(posedge clk); @(negedge clk);
        chk("clr_vs_set", 64'(stk8), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("clr_alone", 64'(stk8), 64'd0);
        @(posedge clk); #1 clr8 = 0;

        // 16-bit boundary
        @(posedge clk); #1 iv16 = 1; a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 0;
        @(posedge clk); #1 iv16 = 0;
        @(posedge clk); @(negedge clk);
`ifdef ADDSUB_SAT_EN
        chk("w16_sum", 64'(sum16), 64'h7FFF);
        chk("w16_nzcv", 64'({n16, z16, c16, v16}), 64'b0001);
`else
        chk("w16_sum", 64'(sum16), 64'h8000);
        chk("w16_nzcv", 64'({n16, z16, c16, v16}), 64'b1001);
`endif

        // 16-bit random traffic with random backpressure
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            iv16   = 1;
            a16    = 16'($urandom);
            b16    = 16'($urandom);
            sub16  = 1'($urandom_range(0, 1));
            ordy16 = ($urandom_range(0, 3) != 0);
            stall  = 0;
            @(negedge clk);
            while (!ir16 && stall <= 100) begin
                @(posedge clk); #1 ordy16 = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                stall++;
            end
            if (stall > 100) begin
                n_total++;
                $display("FAIL rand16_stall: in_ready stuck at 0, required 1 within 100 cycles");
                break;
            end
        end
        @(posedge clk); #1 iv16 = 0; ordy16 = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rand16_drained", 64'(ov16), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
